// File: rtl/mult_pipelined_vr.sv
// Pipelined multiplier with per-stage valid bits, valid/ready backpressure and a
// sideband tag. Stage 1 holds operands, stage 2 the product, later stages delay it.
module mult_pipelined_vr #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int STAGES  = 3,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    input  logic                       sgn,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       busy
);

    localparam int W = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic               sgn_q;
    logic [TAG_W-1:0]   tag1_q;
    logic               v1_q;

    logic [STAGES:1]    v_vec;
    logic [STAGES:1]    ld_vec;
    logic [W-1:0]       prod_s [2:STAGES];
    logic [TAG_W-1:0]   tag_s  [2:STAGES];

    logic [W-1:0]       ext_a;
    logic [W-1:0]       ext_b;
    logic [W-1:0]       prod_d;

    // Extending both operands to the full width makes the low W bits of a plain
    // multiply correct for both unsigned and two's complement modes.
    always_comb begin
        ext_a  = sgn_q ? {{WIDTH_B{a_q[WIDTH_A-1]}}, a_q} : {{WIDTH_B{1'b0}}, a_q};
        ext_b  = sgn_q ? {{WIDTH_A{b_q[WIDTH_B-1]}}, b_q} : {{WIDTH_A{1'b0}}, b_q};
        prod_d = ext_a * ext_b;
    end

    // The ripple "stage i may load if empty or stage i+1 may load" is flattened:
    // stage i may load unless every stage from i to the output is full and stalled.
    for (genvar g = 1; g <= STAGES; g++) begin : g_ld
        assign ld_vec[g] = out_ready || !(&v_vec[STAGES:g]);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v1_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            tag1_q <= '0;
        end else if (ld_vec[1]) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q    <= a;
                b_q    <= b;
                sgn_q  <= sgn;
                tag1_q <= in_tag;
            end
        end
    end

    assign v_vec[1] = v1_q;

    for (genvar g = 2; g <= STAGES; g++) begin : g_stage
        logic             v_q;
        logic [W-1:0]     p_q;
        logic [TAG_W-1:0] t_q;
        logic             v_d;
        logic [W-1:0]     p_d;
        logic [TAG_W-1:0] t_d;

        if (g == 2) begin : g_src_mul
            assign v_d = v1_q;
            assign p_d = prod_d;
            assign t_d = tag1_q;
        end else begin : g_src_dly
            assign v_d = v_vec[g-1];
            assign p_d = prod_s[g-1];
            assign t_d = tag_s[g-1];
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                v_q <= 1'b0;
                p_q <= '0;
                t_q <= '0;
            end else if (ld_vec[g]) begin
                v_q <= v_d;
                if (v_d) begin
                    p_q <= p_d;
                    t_q <= t_d;
                end
            end
        end

        assign v_vec[g]  = v_q;
        assign prod_s[g] = p_q;
        assign tag_s[g]  = t_q;
    end

    assign in_ready  = ld_vec[1];
    assign out_valid = v_vec[STAGES];
    assign result    = prod_s[STAGES];
    assign out_tag   = tag_s[STAGES];
    assign busy      = |v_vec;

endmodule

// File: tb/tb_mult_pipelined_vr.sv
// Bench for mult_pipelined_vr: directed plan steps plus random traffic, checked
// against a queue model of resident transactions and their pipeline positions.
module tb_mult_pipelined_vr;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int ST = 3;
    localparam int TW = 4;
    localparam int W  = WA + WB;

    logic          clk;
    logic          clr_n;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          sgn;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [TW-1:0] out_tag;
    logic          busy;

    mult_pipelined_vr #(
        .WIDTH_A(WA),
        .WIDTH_B(WB),
        .STAGES (ST),
        .TAG_W  (TW)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sgn      (sgn),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: resident transactions in acceptance order, with pipeline position 1..ST.
    int            pos_q[$];
    logic [W-1:0]  res_q[$];
    logic [TW-1:0] tgm_q[$];

    // Producer: pending items, held on the inputs until accepted.
    logic [WA-1:0] pa[$];
    logic [WB-1:0] pb[$];
    logic          ps[$];
    logic [TW-1:0] pt[$];
    bit            acc_last;

    function automatic logic [W-1:0] ref_mul(logic [WA-1:0] x, logic [WB-1:0] y, logic s);
        longint ix, iy, p;
        ix = longint'(x);
        iy = longint'(y);
        if (s && x[WA-1]) ix = ix - (longint'(1) << WA);
        if (s && y[WB-1]) iy = iy - (longint'(1) << WB);
        p = ix * iy;
        return p[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit exp_rdy, exp_ov, acc;
        int lim;
        #1;
        exp_rdy = !(pos_q.size() == ST && !out_ready);
        exp_ov  = (pos_q.size() > 0) && (pos_q[0] == ST);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        chk("busy", busy, pos_q.size() > 0);
        if (exp_ov) begin
            chk("result", result, res_q[0]);
            chk("out_tag", out_tag, tgm_q[0]);
        end
        acc = in_valid && exp_rdy;
        if (exp_ov && out_ready) begin
            void'(pos_q.pop_front());
            void'(res_q.pop_front());
            void'(tgm_q.pop_front());
        end
        lim = ST + 1;
        foreach (pos_q[k]) begin
            if (pos_q[k] + 1 < lim) pos_q[k] = pos_q[k] + 1;
            lim = pos_q[k];
        end
        if (acc) begin
            pos_q.push_back(1);
            res_q.push_back(ref_mul(a, b, sgn));
            tgm_q.push_back(in_tag);
        end
        acc_last = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_item(input logic [WA-1:0] x, input logic [WB-1:0] y,
                             input logic s, input logic [TW-1:0] t);
        pa.push_back(x);
        pb.push_back(y);
        ps.push_back(s);
        pt.push_back(t);
    endtask

    task automatic step(input bit vgate, input bit rdy);
        in_valid = vgate && (pa.size() > 0);
        if (pa.size() > 0) begin
            a      = pa[0];
            b      = pb[0];
            sgn    = ps[0];
            in_tag = pt[0];
        end
        out_ready = rdy;
        tick();
        if (acc_last) begin
            void'(pa.pop_front());
            void'(pb.pop_front());
            void'(ps.pop_front());
            void'(pt.pop_front());
        end
    endtask

    task automatic single(input logic [WA-1:0] x, input logic [WB-1:0] y, input logic s,
                          input logic [TW-1:0] t, input logic [W-1:0] exp_r, input string nm);
        int lat;
        push_item(x, y, s, t);
        step(1'b1, 1'b1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step(1'b0, 1'b1);
            lat++;
        end
        chk({nm, "_latency"}, lat, ST);
        chk({nm, "_result"}, result, exp_r);
        chk({nm, "_tag"}, out_tag, t);
        step(1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt;
        int guard;
        clr_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sgn       = 1'b0;
        in_tag    = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // Single transfer and signed/unsigned corners
        single(8'd200, 8'd100, 1'b0, 4'h5, 16'd20000, "u200x100");
        single(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000, "s80x80");
        single(8'hFF, 8'h02, 1'b1, 4'h2, 16'hFFFE, "sFFx02");
        single(8'hFF, 8'h02, 1'b0, 4'h3, 16'h01FE, "uFFx02");

        // Back-to-back stream
        for (int i = 0; i < 10; i++) push_item(WA'(i), WB'(i + 1), 1'b0, TW'(i));
        ov_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 1'b1);
            if (out_valid) ov_cnt++;
        end
        chk("stream_count", ov_cnt, 10);
        chk("stream_idle", busy, 0);

        // Backpressure: 5 inputs offered while stalled
        for (int i = 0; i < 5; i++) push_item(WA'(8'h31 + i), WB'(8'hC7 - i), 1'(i & 1), TW'(9 + i));
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        for (int c = 0; c < 12; c++) step(1'b1, 1'b1);
        chk("bp_drained", busy, 0);

        // Bubble collapse
        push_item(8'd7, 8'd9, 1'b0, 4'hA);
        push_item(8'hF0, 8'h0F, 1'b1, 4'hB);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("bubble_ready_2res", in_ready, 1);
        push_item(8'd3, 8'd5, 1'b0, 4'hC);
        step(1'b1, 1'b0);
        #1;
        chk("bubble_ready_full", in_ready, 0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1);

        // Asynchronous reset with 3 in flight
        for (int i = 0; i < 3; i++) push_item(WA'(8'h55 + i), WB'(8'h21), 1'b0, TW'(i + 4));
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_out_tag", out_tag, 0);
        pos_q.delete(); res_q.delete(); tgm_q.delete();
        pa.delete(); pb.delete(); ps.delete(); pt.delete();
        @(negedge clk);
        clr_n = 1'b1;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b1);
        single(8'd12, 8'd11, 1'b0, 4'hE, 16'd132, "post_rst");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (pa.size() < 4 && $urandom_range(0, 1) == 1)
                push_item(WA'($urandom), WB'($urandom), 1'($urandom), TW'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        guard = 0;
        while ((pos_q.size() > 0 || pa.size() > 0) && guard < 60) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("rand_drain_bound", guard < 60, 1);
        chk("rand_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
